// File: rtl/button_event_pkg.sv
// Shared types and default constants for the button_event press classifier.
package button_event_pkg;

   typedef enum logic [1:0] {
      WAIT_REL  = 2'd0,
      IDLE      = 2'd1,
      PRESSED   = 2'd2,
      LONG_HELD = 2'd3
   } btn_state_t;

   localparam int LONG_CYCLES_DEF   = 25_000_000;
   localparam int REPEAT_CYCLES_DEF = 5_000_000;
   localparam int CNT_W_DEF         = 25;

endpackage

// File: rtl/button_event_if.sv
// Debounced level in, classified event pulses and held level out.
interface button_event_if;

   logic data_debounced;
   logic press_pulse;
   logic release_pulse;
   logic short_press;
   logic long_press;
   logic repeat_pulse;
   logic held;

   modport master (
      output data_debounced,
      input  press_pulse, release_pulse, short_press, long_press, repeat_pulse, held
   );

   modport slave (
      input  data_debounced,
      output press_pulse, release_pulse, short_press, long_press, repeat_pulse, held
   );

endinterface

// File: rtl/btn_cycle_timer.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
module btn_cycle_timer #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] cmp_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == cmp_i);

endmodule

// File: rtl/button_event.sv
// Press classifier: turns the debounced level into press/release/short/long/repeat pulses.
// Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
//
// state     | meaning
// WAIT_REL  | after reset, waiting for the button to be released before arming
// IDLE      | armed, button released
// PRESSED   | held, long threshold not yet reached
// LONG_HELD | held past the long threshold (auto-repeat region)
module button_event
   import button_event_pkg::*;
#(
   parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   button_event_if.slave  bus
);

   localparam logic [CNT_W-1:0] LONG_CMP   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_CMP = CNT_W'(REPEAT_CYCLES - 1);

   btn_state_t       state_q, state_d;
   logic             cnt_clr, cnt_en, cnt_tc;
   logic [CNT_W-1:0] cnt_cmp;

   logic press_q,   press_d;
   logic release_q, release_d;
   logic short_q,   short_d;
   logic long_q,    long_d;
   logic repeat_d;
   logic held_q,    held_d;

   assign cnt_cmp = (state_q == LONG_HELD) ? REPEAT_CMP : LONG_CMP;

   btn_cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cmp_i (cnt_cmp),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         WAIT_REL: begin
            if (!bus.data_debounced)
               state_d = IDLE;
         end
         IDLE: begin
            if (bus.data_debounced) begin
               state_d = PRESSED;
               cnt_clr = 1'b1;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            // release is checked first so it wins on the threshold cycle
            if (!bus.data_debounced) begin
               state_d   = IDLE;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (cnt_tc) begin
               state_d = LONG_HELD;
               cnt_clr = 1'b1;
               long_d  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         LONG_HELD: begin
            if (!bus.data_debounced) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
               if (cnt_tc) begin
                  cnt_clr  = 1'b1;
                  repeat_d = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
`endif
            end
         end
         default: state_d = WAIT_REL;
      endcase
      held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WAIT_REL;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         held_q    <= held_d;
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   logic repeat_q;

   always_ff @(posedge clk) begin
      if (reset)
         repeat_q <= 1'b0;
      else
         repeat_q <= repeat_d;
   end

   assign bus.repeat_pulse = repeat_q;
`else
   logic unused_repeat;
   assign unused_repeat    = repeat_d;
   assign bus.repeat_pulse = 1'b0;
`endif

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.short_press   = short_q;
   assign bus.long_press    = long_q;
   assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event; the reference model tracks press age in cycles.
module tb_button_event;

   localparam int LONG   = 8;
   localparam int REPEAT = 4;

   logic clk;
   logic reset;

   button_event_if bus ();

   button_event #(
      .LONG_CYCLES   (LONG),
      .REPEAT_CYCLES (REPEAT),
      .CNT_W         (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // model state: armed after release, age = cycles since press pulse (-1 = not held)
   bit  m_wait_rel = 1'b1;
   int  m_age      = -1;
   logic e_press, e_rel, e_short, e_long, e_rep, e_held;

   task automatic model(input logic in, input logic rst);
      e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0;
      if (rst) begin
         m_wait_rel = 1'b1;
         m_age      = -1;
      end else if (m_wait_rel) begin
         if (!in) m_wait_rel = 1'b0;
      end else if (m_age < 0) begin
         if (in) begin
            e_press = 1;
            m_age   = 0;
         end
      end else if (!in) begin
         e_rel   = 1;
         e_short = (m_age < LONG);
         m_age   = -1;
      end else begin
         m_age  = m_age + 1;
         e_long = (m_age == LONG);
`ifdef BUTTON_AUTO_REPEAT_EN
         e_rep  = (m_age > LONG) && (((m_age - LONG) % REPEAT) == 0);
`endif
      end
      e_held = (m_age >= 0);
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
      end
   endtask

   task automatic step(input logic in, input logic rst);
      bus.data_debounced = in;
      reset = rst;
      @(posedge clk);
      model(in, rst);
      #1;
      check("press_pulse",   bus.press_pulse,   e_press);
      check("release_pulse", bus.release_pulse, e_rel);
      check("short_press",   bus.short_press,   e_short);
      check("long_press",    bus.long_press,    e_long);
      check("repeat_pulse",  bus.repeat_pulse,  e_rep);
      check("held",          bus.held,          e_held);
   endtask

   task automatic run(input logic in, input int n);
      for (int i = 0; i < n; i++) step(in, 1'b0);
   endtask

   initial begin
      logic lvl;
      int   len;
      bus.data_debounced = 1'b0;
      reset = 1'b1;

      // reset with input low, then short press of 3 cycles
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      run(1'b0, 8);
      run(1'b1, 3);
      run(1'b0, 10);

      // long hold of 20 cycles (long pulse, repeats when built in)
      run(1'b1, 20);
      run(1'b0, 10);

      // release exactly on the threshold cycle
      run(1'b1, LONG);
      run(1'b0, 10);

      // release on the long pulse cycle
      run(1'b1, LONG + 1);
      run(1'b0, 5);

      // held through reset: no press until released and pressed again
      run(1'b1, 5);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      run(1'b1, 10);
      run(1'b0, 5);
      run(1'b1, 3);
      run(1'b0, 5);

      // randomized hold/release segments with occasional reset
      lvl = 1'b0;
      for (int s = 0; s < 80; s++) begin
         lvl = ~lvl;
         len = $urandom_range(1, 30);
         for (int i = 0; i < len; i++)
            step(lvl, ($urandom_range(0, 99) == 0));
      end
      run(1'b0, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/button_event.md
# button_event

Press classifier directly downstream of the switch debouncer. It takes the clean, debounced button level and turns it into single-cycle event pulses: press, release, short press, long press and optional auto-repeat. It also drives a registered "held" level. Control logic such as the command-trigger sequencer consumes these pulses instead of the raw level.

## Interface
- `LONG_CYCLES`, default 25_000_000. Clock cycles the button must stay held, counted from the press pulse, before it is classified as a long press. Must be ≥ 2.
- `REPEAT_CYCLES`, default 5_000_000. Auto-repeat period once the long-held state is reached. Must be ≥ 2.
- `CNT_W`, default 25. Counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_debounced`  in  1  debounced button level; 1 = pressed. Already synchronous to `clk`.
- `press_pulse`  out  1  one-cycle pulse on a detected press.
- `release_pulse`  out  1  one-cycle pulse on any release.
- `short_press`  out  1  one-cycle pulse when a release happens before the long threshold.
- `long_press`  out  1  one-cycle pulse when the long threshold is reached.
- `repeat_pulse`  out  1  one-cycle pulse every `REPEAT_CYCLES` while long-held.
- `held`  out  1  level; 1 while in PRESSED or LONG_HELD.

## Operation
- **States:** WAIT_REL, IDLE, PRESSED, LONG_HELD. Reset state is WAIT_REL.
- **WAIT_REL:** while input = 1, stay. When input = 0, go to IDLE. No pulses are generated, so a button held through reset never produces a press.
- **IDLE:** when input = 1, go to PRESSED, clear the counter and pulse `press_pulse`.
- **PRESSED, input = 0:** go to IDLE and pulse `release_pulse` and `short_press` in the same cycle.
- **PRESSED, input = 1, counter == LONG_CYCLES-1:** go to LONG_HELD, clear the counter and pulse `long_press`.
- **PRESSED, otherwise:** counter += 1.
- **LONG_HELD, input = 0:** go to IDLE and pulse `release_pulse` only.
- **LONG_HELD, input = 1:** counter behaviour depends on the configuration macro (see Configuration).
- **Release priority:** release beats the threshold. If input = 0 on the threshold cycle, the press is classified as short and `long_press` does not fire.
- **Pulse exclusivity:** at most one of `press_pulse`, `long_press`, `repeat_pulse` is high in any cycle. `release_pulse` coincides only with `short_press`.
- **Counter arithmetic:** unsigned, `CNT_W` bits. It never wraps past its compare value.

## Timing
- All outputs are registered. Every output resets to 0 in the cycle after `reset` is sampled high.
- **Press latency:** input first sampled 1 in cycle N (state IDLE) → `press_pulse` high in cycle N+1, and `held` = 1 from N+1.
- **Long latency:** `long_press` is high exactly `LONG_CYCLES` cycles after `press_pulse`.
- **Repeat timing:** the first `repeat_pulse` comes `REPEAT_CYCLES` cycles after `long_press`, then one every `REPEAT_CYCLES` cycles.
- **Release latency:** input first sampled 0 in cycle M → `release_pulse` high in M+1, and `held` = 0 from M+1.
- **Reset mid-operation:** state goes to WAIT_REL, the counter clears, and no pulse fires for the interrupted press.

## Configuration
- **`BUTTON_AUTO_REPEAT_EN` defined:**
  - In LONG_HELD, the counter increments.
  - When the counter == REPEAT_CYCLES-1, pulse `repeat_pulse` and reset the counter to 0.
- **Macro undefined:**
  - No repeat logic is built and `repeat_pulse` is tied to 0.
  - The counter holds in LONG_HELD.
  - `REPEAT_CYCLES` is ignored.

## Structure
- **Package `button_event_pkg`:**
  - State enum `btn_state_t` (WAIT_REL, IDLE, PRESSED, LONG_HELD), 2 bits.
  - Default constants for `LONG_CYCLES` and `REPEAT_CYCLES`.
- **Sub-module `btn_cycle_timer`:** counter with clear, enable and terminal-count compare. It is instantiated once; the compare value is muxed by state between LONG_CYCLES-1 and REPEAT_CYCLES-1.
- The FSM and output registers live in the top module.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `REPEAT_CYCLES`=4.
1. **Short press:** reset with input 0; raise input at cycle 10 for 3 cycles → `press_pulse` at 11; `release_pulse`+`short_press` at 14; `long_press` never fires; `held` high for cycles 11–13.
2. **Long press with repeat (macro defined):** raise input at cycle 10 and hold 20 cycles → `press_pulse` at 11; `long_press` at 19; `repeat_pulse` at 23, 27; `release_pulse` alone at 31.
3. **Release on the threshold cycle:** input high for cycles 10–17 and low at 18 → `short_press`+`release_pulse` at 19; no `long_press`.
4. **Held through reset:** reset asserted for cycles 5–6 while input is 1 → all outputs 0; no `press_pulse` while input stays 1. Drop input low then raise it at cycle 20 → `press_pulse` at 21.
5. **No repeat (macro undefined):** same stimulus as scenario 2 → `long_press` at 19 only; `repeat_pulse` stays 0; `release_pulse` at 31.
